// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and sizing for the pipeline hazard controller and its helpers.
// Also provides a saturating increment for the stall statistics counter.
package pipeline_ctrl_pkg;

    localparam int REG_AW_DEF  = 5;
    localparam int STALL_CNT_W = 16;
    localparam int WAIT_CNT_W  = 8;
    localparam int FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        ERR_FLUSH = 2'd2
    } ctrl_state_e;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == {STALL_CNT_W{1'b1}}) ? v : v + STALL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare between the load in EX and the operands in ID.
// Register x0 is hardwired to zero, so it never creates a dependency.
module load_use_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              i_ex_mem_read,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    output logic              o_lu
);

    logic w_rd_nonzero;
    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_rd_nonzero = (i_ex_rd != '0);
    assign w_hit_rs1    = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_hit_rs2    = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    assign o_lu         = i_ex_mem_read && w_rd_nonzero && (w_hit_rs1 || w_hit_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use bubbles, branch flushes,
// data-memory wait freezes and the trap flush that follows a memory timeout.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int MAX_WAIT     = 15,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ID_EX_MemRead,
    input  logic [REG_AW-1:0]      ID_EX_rd,
    input  logic [REG_AW-1:0]      IF_ID_rs1,
    input  logic [REG_AW-1:0]      IF_ID_rs2,
    input  logic                   IF_ID_use_rs1,
    input  logic                   IF_ID_use_rs2,
    input  logic                   branch_taken,
    input  logic                   mem_req,
    input  logic                   mem_ack,
    input  logic                   stall_cnt_clr,
    output logic                   pc_write,
    output logic                   pc_sel_trap,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_write,
    output logic                   id_ex_flush,
    output logic                   ex_mem_write,
    output logic                   ex_mem_flush,
    output logic                   mem_wb_flush,
    output logic                   mem_timeout,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [WAIT_CNT_W-1:0]  MAX_WAIT_V   = WAIT_CNT_W'(MAX_WAIT);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST_V = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    ctrl_state_e             r_state;
    ctrl_state_e             w_state_nxt;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic [WAIT_CNT_W-1:0]   w_wait_cnt_nxt;
    logic [FLUSH_CNT_W-1:0]  r_flush_cnt;
    logic [FLUSH_CNT_W-1:0]  w_flush_cnt_nxt;
    logic [STALL_CNT_W-1:0]  r_stall_cnt;
    logic                    w_lu;
    logic                    w_run_rules;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_lu (
        .i_ex_mem_read (ID_EX_MemRead),
        .i_ex_rd       (ID_EX_rd),
        .i_id_rs1      (IF_ID_rs1),
        .i_id_rs2      (IF_ID_rs2),
        .i_id_use_rs1  (IF_ID_use_rs1),
        .i_id_use_rs2  (IF_ID_use_rs2),
        .o_lu          (w_lu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            if (stall_cnt_clr) begin
                r_stall_cnt <= '0;
            end else if (!pc_write) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    // Controls are combinational so a stall takes effect in the same cycle it is detected.
    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_flush_cnt_nxt = r_flush_cnt;
        w_run_rules     = 1'b0;
        pc_write        = 1'b1;
        pc_sel_trap     = 1'b0;
        if_id_write     = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_write     = 1'b1;
        id_ex_flush     = 1'b0;
        ex_mem_write    = 1'b1;
        ex_mem_flush    = 1'b0;
        mem_wb_flush    = 1'b0;
        mem_timeout     = 1'b0;

        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (mem_req && !mem_ack) begin
                        pc_write       = 1'b0;
                        if_id_write    = 1'b0;
                        id_ex_write    = 1'b0;
                        ex_mem_write   = 1'b0;
                        mem_wb_flush   = 1'b1;
                        w_state_nxt    = MEM_WAIT;
                        w_wait_cnt_nxt = WAIT_CNT_W'(1);
                    end else begin
                        w_run_rules = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        w_run_rules    = 1'b1;
                        w_state_nxt    = RUN;
                        w_wait_cnt_nxt = '0;
                    end else begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_flush = 1'b1;
                        if (r_wait_cnt == MAX_WAIT_V) begin
                            mem_timeout     = 1'b1;
                            w_state_nxt     = ERR_FLUSH;
                            w_wait_cnt_nxt  = '0;
                            w_flush_cnt_nxt = '0;
                        end else begin
                            w_wait_cnt_nxt = r_wait_cnt + WAIT_CNT_W'(1);
                        end
                    end
                end
                ERR_FLUSH: begin
                    // Only the first flush cycle redirects fetch; the rest just drain bubbles.
                    pc_write     = (r_flush_cnt == '0);
                    pc_sel_trap  = (r_flush_cnt == '0);
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    mem_wb_flush = 1'b1;
                    if (r_flush_cnt >= FLUSH_LAST_V) begin
                        w_state_nxt     = RUN;
                        w_flush_cnt_nxt = '0;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt + FLUSH_CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt     = RUN;
                    w_wait_cnt_nxt  = '0;
                    w_flush_cnt_nxt = '0;
                end
            endcase

            // A taken branch squashes the wrong-path ID instruction, so it beats load-use.
            if (w_run_rules) begin
                if (branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (w_lu) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each driven cycle queues its expected
// control vector and stall count, popped and compared at the following negedge.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic       req;
        logic       ack;
        logic       clr;
    } stim_t;

    typedef struct {
        logic [9:0]  ctl;
        logic [15:0] stall;
        string       tag;
    } exp_t;

    // Bit order: pcw trap ifw iff idw idf exw exf wbf to
    localparam logic [9:0] DEF  = 10'b1010101000;
    localparam logic [9:0] FRZ  = 10'b0000000010;
    localparam logic [9:0] LU   = 10'b0000111000;
    localparam logic [9:0] BR   = 10'b1011111000;
    localparam logic [9:0] RST  = 10'b0001010110;
    localparam logic [9:0] TO   = 10'b0000000011;
    localparam logic [9:0] TRAP = 10'b1101010110;
    localparam logic [9:0] FLO  = 10'b0001010110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ID_EX_MemRead = 1'b0;
    logic [4:0]  ID_EX_rd = '0;
    logic [4:0]  IF_ID_rs1 = '0;
    logic [4:0]  IF_ID_rs2 = '0;
    logic        IF_ID_use_rs1 = 1'b0;
    logic        IF_ID_use_rs2 = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ack = 1'b0;
    logic        stall_cnt_clr = 1'b0;
    logic        pc_write, pc_sel_trap, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic        ex_mem_write, ex_mem_flush, mem_wb_flush, mem_timeout;
    logic [15:0] stall_cnt;
    logic [9:0]  w_act;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_stall = '0;
    exp_t        sbq[$];

    pipeline_hazard_ctrl #(
        .REG_AW       (5),
        .MAX_WAIT     (15),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ID_EX_MemRead (ID_EX_MemRead),
        .ID_EX_rd      (ID_EX_rd),
        .IF_ID_rs1     (IF_ID_rs1),
        .IF_ID_rs2     (IF_ID_rs2),
        .IF_ID_use_rs1 (IF_ID_use_rs1),
        .IF_ID_use_rs2 (IF_ID_use_rs2),
        .branch_taken  (branch_taken),
        .mem_req       (mem_req),
        .mem_ack       (mem_ack),
        .stall_cnt_clr (stall_cnt_clr),
        .pc_write      (pc_write),
        .pc_sel_trap   (pc_sel_trap),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .id_ex_write   (id_ex_write),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_flush  (ex_mem_flush),
        .mem_wb_flush  (mem_wb_flush),
        .mem_timeout   (mem_timeout),
        .stall_cnt     (stall_cnt)
    );

    assign w_act = {pc_write, pc_sel_trap, if_id_write, if_id_flush, id_ex_write,
                    id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_flush, mem_timeout};

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic u1, input logic u2,
                                 input logic br, input logic req, input logic ack, input logic clr);
        stim_t s;
        s = '{mr, rd, rs1, rs2, u1, u2, br, req, ack, clr};
        return s;
    endfunction

    localparam stim_t IDLE = '0;

    // Drive one cycle of stimulus, queue its expectation, advance to the sampling edge.
    task automatic drive(input stim_t s, input logic [9:0] e, input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        ID_EX_MemRead = s.mr;
        ID_EX_rd      = s.rd;
        IF_ID_rs1     = s.rs1;
        IF_ID_rs2     = s.rs2;
        IF_ID_use_rs1 = s.u1;
        IF_ID_use_rs2 = s.u2;
        branch_taken  = s.br;
        mem_req       = s.req;
        mem_ack       = s.ack;
        stall_cnt_clr = s.clr;
        x.ctl   = e;
        x.stall = exp_stall;
        x.tag   = tag;
        sbq.push_back(x);
        if (s.clr) exp_stall = '0;
        else if (!e[9] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (w_act !== RST) begin
            failures++;
            $display("FAIL reset_ctl: got %b expected %b", w_act, RST);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_stall: got %0d expected 0", stall_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_stall = '0;
        for (int i = 0; i < 2; i++) begin
            exp_t x;
            drive(IDLE, DEF, "post_reset");
            x = sbq.pop_front();
            checks++;
            if (w_act !== x.ctl) begin
                failures++;
                $display("FAIL %s ctl[%0d]: got %b expected %b", x.tag, i, w_act, x.ctl);
            end
            checks++;
            if (stall_cnt !== x.stall) begin
                failures++;
                $display("FAIL %s stall[%0d]: got %0d expected %0d", x.tag, i, stall_cnt, x.stall);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t      st[5];
        logic [9:0] ex[5];
        st = '{mk(0,0,0,0,0,0,0,0,0,1), mk(1,5,3,5,1,1,0,0,0,0), mk(0,0,0,0,0,0,0,0,0,0),
               mk(1,7,7,2,1,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0,0)};
        ex = '{DEF, LU, DEF, LU, DEF};
        for (int i = 0; i < 5; i++) begin
            exp_t x;
            drive(st[i], ex[i], "load_use");
            x = sbq.pop_front();
            checks++;
            if (w_act !== x.ctl) begin
                failures++;
                $display("FAIL %s ctl[%0d]: got %b expected %b", x.tag, i, w_act, x.ctl);
            end
            checks++;
            if (stall_cnt !== x.stall) begin
                failures++;
                $display("FAIL %s stall[%0d]: got %0d expected %0d", x.tag, i, stall_cnt, x.stall);
            end
        end
    endtask

    task automatic test_no_stall();
        stim_t      st[5];
        logic [9:0] ex[5];
        st = '{mk(0,0,0,0,0,0,0,0,0,1), mk(1,0,0,0,1,1,0,0,0,0), mk(1,5,3,5,0,0,0,0,0,0),
               mk(0,5,5,5,1,1,0,0,0,0), mk(1,5,5,9,0,1,0,0,0,0)};
        ex = '{DEF, DEF, DEF, DEF, DEF};
        for (int i = 0; i < 5; i++) begin
            exp_t x;
            drive(st[i], ex[i], "no_stall");
            x = sbq.pop_front();
            checks++;
            if (w_act !== x.ctl) begin
                failures++;
                $display("FAIL %s ctl[%0d]: got %b expected %b", x.tag, i, w_act, x.ctl);
            end
            checks++;
            if (stall_cnt !== x.stall) begin
                failures++;
                $display("FAIL %s stall[%0d]: got %0d expected %0d", x.tag, i, stall_cnt, x.stall);
            end
        end
    endtask

    task automatic test_branch_over_lu();
        stim_t      st[4];
        logic [9:0] ex[4];
        st = '{mk(1,5,3,5,1,1,1,0,0,0), mk(0,0,0,0,0,0,1,0,0,0), mk(0,0,0,0,0,0,0,1,1,0),
               mk(0,0,0,0,0,0,0,0,0,0)};
        ex = '{BR, BR, DEF, DEF};
        for (int i = 0; i < 4; i++) begin
            exp_t x;
            drive(st[i], ex[i], "branch_lu");
            x = sbq.pop_front();
            checks++;
            if (w_act !== x.ctl) begin
                failures++;
                $display("FAIL %s ctl[%0d]: got %b expected %b", x.tag, i, w_act, x.ctl);
            end
        end
    endtask

    task automatic test_mem_wait_ack();
        stim_t      st[10];
        logic [9:0] ex[10];
        st = '{mk(0,0,0,0,0,0,0,0,0,1), mk(0,0,0,0,0,0,1,1,0,0), mk(1,5,5,0,1,0,1,1,0,0),
               mk(0,0,0,0,0,0,0,1,0,0), mk(0,0,0,0,0,0,0,1,1,0), mk(0,0,0,0,0,0,0,0,0,0),
               mk(0,0,0,0,0,0,0,1,0,0), mk(0,0,0,0,0,0,1,1,1,0), mk(0,0,0,0,0,0,0,1,0,0),
               mk(1,4,4,0,1,0,0,1,1,0)};
        ex = '{DEF, FRZ, FRZ, FRZ, DEF, DEF, FRZ, BR, FRZ, LU};
        for (int i = 0; i < 10; i++) begin
            exp_t x;
            drive(st[i], ex[i], "mem_wait");
            x = sbq.pop_front();
            checks++;
            if (w_act !== x.ctl) begin
                failures++;
                $display("FAIL %s ctl[%0d]: got %b expected %b", x.tag, i, w_act, x.ctl);
            end
            checks++;
            if (stall_cnt !== x.stall) begin
                failures++;
                $display("FAIL %s stall[%0d]: got %0d expected %0d", x.tag, i, stall_cnt, x.stall);
            end
        end
    endtask

    task automatic test_timeout();
        drive(mk(0,0,0,0,0,0,0,0,0,1), DEF, "timeout_clr");
        void'(sbq.pop_front());
        for (int i = 0; i < 20; i++) begin
            exp_t       x;
            stim_t      s;
            logic [9:0] e;
            s = mk(1,5,5,0,1,0,1,1,0,0);
            if (i < 15)       e = FRZ;
            else if (i == 15) e = TO;
            else if (i == 16) begin e = TRAP; s = mk(1,5,5,0,1,0,1,1,1,0); end
            else if (i == 17) e = FLO;
            else begin e = DEF; s = IDLE; end
            drive(s, e, "timeout");
            x = sbq.pop_front();
            checks++;
            if (w_act !== x.ctl) begin
                failures++;
                $display("FAIL %s ctl[%0d]: got %b expected %b", x.tag, i, w_act, x.ctl);
            end
            checks++;
            if (stall_cnt !== x.stall) begin
                failures++;
                $display("FAIL %s stall[%0d]: got %0d expected %0d", x.tag, i, stall_cnt, x.stall);
            end
        end
    endtask

    task automatic test_ack_at_limit();
        for (int i = 0; i < 18; i++) begin
            exp_t       x;
            stim_t      s;
            logic [9:0] e;
            s = mk(0,0,0,0,0,0,0,1,0,0);
            e = FRZ;
            if (i == 15) begin s = mk(0,0,0,0,0,0,0,1,1,0); e = DEF; end
            else if (i > 15) begin s = IDLE; e = DEF; end
            drive(s, e, "ack_at_limit");
            x = sbq.pop_front();
            checks++;
            if (w_act !== x.ctl) begin
                failures++;
                $display("FAIL %s ctl[%0d]: got %b expected %b", x.tag, i, w_act, x.ctl);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 3; i++) begin
            exp_t x;
            drive(mk(0,0,0,0,0,0,0,1,0,0), FRZ, "rst_wait");
            x = sbq.pop_front();
            checks++;
            if (w_act !== x.ctl) begin
                failures++;
                $display("FAIL %s ctl[%0d]: got %b expected %b", x.tag, i, w_act, x.ctl);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (w_act !== RST) begin
            failures++;
            $display("FAIL rst_wait_async_ctl: got %b expected %b", w_act, RST);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL rst_wait_async_stall: got %0d expected 0", stall_cnt);
        end
        exp_stall = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_t x;
            drive(IDLE, DEF, "rst_wait_after");
            x = sbq.pop_front();
            checks++;
            if (w_act !== x.ctl) begin
                failures++;
                $display("FAIL %s ctl[%0d]: got %b expected %b", x.tag, i, w_act, x.ctl);
            end
            checks++;
            if (stall_cnt !== x.stall) begin
                failures++;
                $display("FAIL %s stall[%0d]: got %0d expected %0d", x.tag, i, stall_cnt, x.stall);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch_over_lu();
        test_mem_wait_ack();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
